// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues word fetches, buffers {inst, pc} for decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;

  logic [31:0]   inflight [BUF_DEPTH];
  logic [PW-1:0] if_wr, if_rd;

  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [PW-1:0] b_wr, b_rd;
  logic [CW-1:0] b_cnt, b_cnt_nxt;

  logic          credit_ok, req_fire, rsp_take, rsp_keep, out_pop;

  // Credits cover both in-flight fetches and buffered entries, so the buffer can never overflow.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, b_cnt}) < (CW + 1)'(BUF_DEPTH);

  assign out_valid     = (b_cnt != '0);
  assign out_inst      = buf_inst[b_rd];
  assign out_pc        = buf_pc[b_rd];
  assign imem_req_addr = fetch_pc;

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    imem_req_valid  = (state == RUN) && credit_ok && !redirect_valid && !rst;
    req_fire        = imem_req_valid && imem_req_ready;
    rsp_take        = imem_rsp_valid && (outstanding != '0);
    rsp_keep        = rsp_take && (state == RUN) && !redirect_valid;
    out_pop         = out_valid && out_ready && !redirect_valid;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_take);
    b_cnt_nxt       = redirect_valid ? '0 : (b_cnt + CW'(rsp_keep) - CW'(out_pop));
    if (req_fire)
      fetch_pc_nxt = fetch_pc + 32'd4;
    if (redirect_valid)
      fetch_pc_nxt = {redirect_target[31:2], 2'b00};
    unique case (state)
      RUN:     if (redirect_valid && (outstanding_nxt != '0)) state_nxt = DRAIN;
      DRAIN:   if (outstanding_nxt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      if_wr       <= '0;
      if_rd       <= '0;
      b_wr        <= '0;
      b_rd        <= '0;
      b_cnt       <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        inflight[i] <= '0;
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      b_cnt       <= b_cnt_nxt;
      if (req_fire) begin
        inflight[if_wr] <= fetch_pc;
        if_wr           <= if_wr + PW'(1);
      end
      if (rsp_take)
        if_rd <= if_rd + PW'(1);
      // A flush empties the buffer by realigning both pointers; stale entries stay in the array.
      if (redirect_valid) begin
        b_wr <= '0;
        b_rd <= '0;
      end else begin
        if (rsp_keep) begin
          buf_inst[b_wr] <= imem_rsp_data;
          buf_pc[b_wr]   <= inflight[if_rd];
          b_wr           <= b_wr + PW'(1);
        end
        if (out_pop)
          b_rd <= b_rd + PW'(1);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(out_pop);
      perf_flushed <= perf_flushed + (redirect_valid ? 32'(b_cnt) : 32'd0)
                      + 32'(rsp_take && !rsp_keep);
    end
  end
`endif

  rsp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-based fetch model.
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  int checks = 0, failures = 0, cyc = 0;

  // reference model
  logic [31:0] m_pc;
  int          m_out;
  logic [31:0] m_inflight[$];
  logic [31:0] m_buf[$];
  bit          m_drain;
  logic [31:0] m_fetched, m_flushed;

  // memory
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          last_due;

  // knobs
  int          lat_min = 1, lat_max = 1, p_rrdy = 100, p_ordy = 100, p_redir = 0;
  bit          force_redir = 0, redir_on_rsp_out = 0, redir_fired = 0;
  logic [31:0] force_tgt = '0;

  // logs
  logic [31:0] acc_q[$];
  logic [31:0] pop_q[$];
  int          first_acc, first_ov, redir_pop_idx;
  logic        last_req_valid, last_out_valid;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    pop_q.delete();
    first_acc = -1;
    first_ov = -1;
    redir_fired = 0;
    redir_pop_idx = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    @(posedge clk);
    m_pc = RPC; m_out = 0; m_inflight.delete(); m_buf.delete(); m_drain = 0;
    m_fetched = '0; m_flushed = '0;
    mem_addr.delete(); mem_due.delete(); last_due = -1;
    cyc = 0;
    clear_logs();
  endtask

  task automatic step();
    logic rv, rsp, rr, orr, exp_rv, hs, pop, mfire;
    logic [31:0] tgt, hs_addr, pop_pc, a;
    int lat, due;
    @(negedge clk);
    rst = 1'b0;
    rsp = (mem_addr.size() > 0) && (mem_due[0] <= cyc);
    rr  = ($urandom_range(99) < p_rrdy);
    orr = ($urandom_range(99) < p_ordy);
    rv  = ($urandom_range(999) < p_redir);
    tgt = $urandom;
    if (force_redir) begin rv = 1'b1; tgt = force_tgt; force_redir = 0; end
    if (redir_on_rsp_out && rsp && m_buf.size() > 0) begin
      rv = 1'b1; tgt = force_tgt; redir_on_rsp_out = 0;
    end
    imem_req_ready  = rr;
    imem_rsp_valid  = rsp;
    imem_rsp_data   = rsp ? inst_of(mem_addr[0]) : $urandom;
    redirect_valid  = rv;
    redirect_target = tgt;
    out_ready       = orr;
    #1;
    exp_rv = !m_drain && (m_out + m_buf.size() < DEPTH) && !rv;
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, m_pc);
    chk("out_valid", out_valid, m_buf.size() > 0);
    if (m_buf.size() > 0) begin
      chk("out_pc", out_pc, m_buf[0]);
      chk("out_inst", out_inst, inst_of(m_buf[0]));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
`endif
    hs = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    pop = out_valid && out_ready && !rv;
    pop_pc = out_pc;
    last_req_valid = imem_req_valid;
    last_out_valid = out_valid;
    if (rv && !redir_fired) begin redir_fired = 1; redir_pop_idx = pop_q.size(); end
    @(posedge clk);
    // memory side, driven by what the DUT actually did
    if (rsp) begin void'(mem_addr.pop_front()); void'(mem_due.pop_front()); end
    if (hs) begin
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_addr.push_back(hs_addr); mem_due.push_back(due); last_due = due;
      acc_q.push_back(hs_addr);
      if (first_acc < 0) first_acc = cyc;
    end
    if (last_out_valid && first_ov < 0) first_ov = cyc;
    if (pop) pop_q.push_back(pop_pc);
    // model update
    mfire = exp_rv && rr;
    if (m_buf.size() > 0 && orr && !rv) begin void'(m_buf.pop_front()); m_fetched++; end
    if (rsp && m_out > 0) begin
      a = m_inflight.pop_front();
      m_out--;
      if (!m_drain && !rv) m_buf.push_back(a);
      else m_flushed++;
    end
    if (rv) begin
      m_flushed += m_buf.size();
      m_buf.delete();
      m_pc = {tgt[31:2], 2'b00};
    end
    if (mfire) begin m_inflight.push_back(m_pc); m_out++; m_pc += 32'd4; end
    if (rv) m_drain = (m_out != 0);
    else if (m_drain && m_out == 0) m_drain = 0;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;

    // basic stream: 0x100, 0x104, 0x108, two-cycle minimum latency
    do_reset();
    for (int i = 0; i < 12; i++) step();
    chk("A_pops", pop_q.size() >= 3, 1);
    if (pop_q.size() >= 3) begin
      chk("A_pc0", pop_q[0], 32'h100);
      chk("A_pc1", pop_q[1], 32'h104);
      chk("A_pc2", pop_q[2], 32'h108);
    end
    chk("A_latency", first_ov - first_acc, 2);

    // downstream stall: two requests fill the buffer, then drain in order
    do_reset();
    p_ordy = 0;
    for (int i = 0; i < 10; i++) step();
    chk("B_reqs", acc_q.size(), 2);
    chk("B_req_valid", last_req_valid, 0);
    chk("B_out_valid", last_out_valid, 1);
    p_ordy = 100;
    clear_logs();
    for (int i = 0; i < 6; i++) step();
    chk("B_pops", pop_q.size() >= 2, 1);
    chk("B_accs", acc_q.size() >= 1, 1);
    if (pop_q.size() >= 2) begin
      chk("B_pc0", pop_q[0], 32'h100);
      chk("B_pc1", pop_q[1], 32'h104);
    end
    if (acc_q.size() >= 1) chk("B_resume", acc_q[0], 32'h108);

    // redirect with two slow fetches outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    step(); step();
    clear_logs();
    force_redir = 1; force_tgt = 32'h0000_0202;
    for (int i = 0; i < 12; i++) step();
    chk("C_accs", acc_q.size() >= 1, 1);
    chk("C_pops", pop_q.size() >= 1, 1);
    if (acc_q.size() >= 1) chk("C_req0", acc_q[0], 32'h200);
    if (pop_q.size() >= 1) chk("C_pc0", pop_q[0], 32'h200);

    // redirect colliding with a response and a pop
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) step();
    redir_on_rsp_out = 1; force_tgt = 32'h0000_0400;
    for (int i = 0; i < 20 && !redir_fired; i++) step();
    chk("D_fired", redir_fired, 1);
    step();
    chk("D_flushed", last_out_valid, 0);
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < redir_pop_idx; i++) chk("D_pre", pop_q[i], 32'h100 + 32'(4 * i));
    chk("D_post_exists", pop_q.size() > redir_pop_idx, 1);
    if (pop_q.size() > redir_pop_idx) chk("D_post", pop_q[redir_pop_idx], 32'h400);
    redir_on_rsp_out = 0;

    // PC wrap at the top of the address space
    do_reset();
    force_redir = 1; force_tgt = 32'hFFFF_FFFE;
    for (int i = 0; i < 6; i++) step();
    chk("E_accs", acc_q.size() >= 2, 1);
    if (acc_q.size() >= 2) begin
      chk("E_top", acc_q[0], 32'hFFFF_FFFC);
      chk("E_wrap", acc_q[1], 32'h0000_0000);
    end

    // random traffic with a mid-run reset
    do_reset();
    lat_min = 1; lat_max = 4; p_rrdy = 70; p_ordy = 60; p_redir = 40;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
